// File: rtl/timer_capture_arb.sv
// timer_capture_arb: round-robin arbiter that grants one requester at a time
// access to a timer capture strobe. It snapshots the timer count on the grant
// edge, and then enforces GAP_CYCLES idle cycles before the next grant.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en_i        arbitration enable (only gates IDLE->CAP)
//   req_i       level capture requests, one bit per requester
//   count_i     free-running timer count
//   capture_o   one-cycle capture strobe
//   grant_o     one-hot grant, non-zero only while capture_o is high
//   cap_data_o  count snapshot taken on the grant edge
//   busy_o      high whenever the FSM is not in IDLE
//   last_id_o   index of the most recently granted requester
module timer_capture_arb #(
  parameter int NUM_REQ    = 4,
  parameter int CNT_W      = 32,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [CNT_W-1:0]   count_i,
  output logic               capture_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [CNT_W-1:0]   cap_data_o,
  output logic               busy_o,
  output logic [2:0]         last_id_o
);

  // HOLD counts down from GAP_CYCLES-1 to 0, giving GAP_CYCLES HOLD cycles.
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    CAP,
    HOLD
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] hold_cnt;
  logic       found;
  logic [2:0] win_id;
  logic [3:0] cand;
  logic [7:0] req_ext;
  logic       take;

  // Round-robin search: start one past the last winner, ascend with wrap.
  always_comb begin
    found   = 1'b0;
    win_id  = '0;
    cand    = '0;
    req_ext = 8'(req_i);
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_id_o} + 4'(i);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!found && req_ext[cand[2:0]]) begin
        found  = 1'b1;
        win_id = cand[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (en_i && found) state_next = CAP;
      CAP:  state_next = (GAP_CYCLES > 0) ? HOLD : IDLE;
      HOLD: if (hold_cnt == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign take   = (state == IDLE) && (state_next == CAP);
  assign busy_o = (state != IDLE);

  // Strobe and grant are registered alongside the state so they line up
  // exactly with the CAP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      capture_o  <= 1'b0;
      grant_o    <= '0;
      cap_data_o <= '0;
      last_id_o  <= 3'(NUM_REQ - 1);
      hold_cnt   <= '0;
    end else begin
      capture_o <= take;
      grant_o   <= take ? (NUM_REQ'(1) << win_id) : '0;
      if (take) begin
        cap_data_o <= count_i;
        last_id_o  <= win_id;
      end
      if (state == CAP) begin
        hold_cnt <= GAP_LOAD;
      end else if (state == HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_timer_capture_arb.sv
module tb_timer_capture_arb;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] count = '0;
  logic        capture;
  logic [3:0]  grant;
  logic [31:0] cap_data;
  logic        busy;
  logic [2:0]  last_id;

  // Second instance with no gap.
  logic        rst0 = 1'b1;
  logic        en0 = 1'b0;
  logic [3:0]  req0 = '0;
  logic        capture0;
  logic [3:0]  grant0;
  logic [31:0] cap_data0;
  logic        busy0;
  logic [2:0]  last_id0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_capture_arb #(.NUM_REQ(4), .CNT_W(32), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .en_i(en), .req_i(req), .count_i(count),
    .capture_o(capture), .grant_o(grant), .cap_data_o(cap_data),
    .busy_o(busy), .last_id_o(last_id)
  );

  timer_capture_arb #(.NUM_REQ(4), .CNT_W(32), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .en_i(en0), .req_i(req0), .count_i(32'h0000_1234),
    .capture_o(capture0), .grant_o(grant0), .cap_data_o(cap_data0),
    .busy_o(busy0), .last_id_o(last_id0)
  );

  // Reference model: m_busy = number of non-idle cycles remaining, counting
  // the cycle currently on the outputs.
  int          m_busy;
  logic [2:0]  m_last;
  logic        m_cap;
  logic [3:0]  m_grant;
  logic [31:0] m_data;

  task automatic model_edge(input logic r, input logic e, input logic [3:0] q,
                            input logic [31:0] c);
    int id;
    if (r) begin
      m_busy = 0; m_cap = 1'b0; m_grant = '0; m_data = '0; m_last = 3'd3;
    end else begin
      m_cap = 1'b0;
      m_grant = '0;
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
      end else if (e && q != 4'd0) begin
        id = -1;
        for (int k = 1; k <= 4; k++) begin
          if (id < 0 && q[(int'(m_last) + k) % 4]) id = (int'(m_last) + k) % 4;
        end
        m_busy  = 1 + GAP;
        m_cap   = 1'b1;
        m_grant = 4'(1 << id);
        m_data  = c;
        m_last  = 3'(id);
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] q,
                      input logic [31:0] c);
    @(negedge clk);
    rst = r; en = e; req = q; count = c;
    @(posedge clk);
    model_edge(r, e, q, c);
    #1;
  endtask

  task automatic check_model(input string nm);
    check({nm, ".capture"}, 32'(capture), 32'(m_cap));
    check({nm, ".grant"}, 32'(grant), 32'(m_grant));
    check({nm, ".cap_data"}, cap_data, m_data);
    check({nm, ".busy"}, 32'(busy), 32'(m_busy > 0));
    check({nm, ".last_id"}, 32'(last_id), 32'(m_last));
  endtask

  typedef struct {
    logic        r;
    logic        e;
    logic [3:0]  q;
    logic [31:0] c;
    logic        cap;
    logic [3:0]  g;
    logic [31:0] d;
    logic        b;
    logic [2:0]  l;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cap_n;
    int prev_t;
    int got;
    logic [3:0] exp_g[5];

    // Single request, hold timing, count wrap, reset mid-HOLD.
    tbl.push_back('{1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 3'd3});
    tbl.push_back('{1'b0, 1'b1, 4'b0100, 32'h1000,     1'b1, 4'b0100, 32'h1000,     1'b1, 3'd2});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 1'b1, 4'b0000, 32'h5,      1'b0, 4'b0000, 32'h1000,     1'b1, 3'd2});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 32'h5,        1'b0, 4'b0000, 32'h1000,     1'b0, 3'd2});
    tbl.push_back('{1'b0, 1'b1, 4'b0001, 32'hFFFFFFFF, 1'b1, 4'b0001, 32'hFFFFFFFF, 1'b1, 3'd0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 1'b1, 4'b0001, 32'h7,      1'b0, 4'b0000, 32'hFFFFFFFF, 1'b1, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 4'b0001, 32'h7,        1'b0, 4'b0000, 32'hFFFFFFFF, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 4'b0001, 32'h3,        1'b1, 4'b0001, 32'h3,        1'b1, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 4'b0110, 32'h9,        1'b0, 4'b0000, 32'h3,        1'b1, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 4'b0110, 32'h9,        1'b0, 4'b0000, 32'h3,        1'b1, 3'd0});
    tbl.push_back('{1'b1, 1'b1, 4'b0110, 32'h9,        1'b0, 4'b0000, 32'h0,        1'b0, 3'd3});
    tbl.push_back('{1'b0, 1'b1, 4'b0110, 32'h55,       1'b1, 4'b0010, 32'h55,       1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 4'b0110, 32'h56,       1'b0, 4'b0000, 32'h55,       1'b1, 3'd1});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].q, tbl[i].c);
      check($sformatf("vec%0d.capture", i), 32'(capture), 32'(tbl[i].cap));
      check($sformatf("vec%0d.grant", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("vec%0d.cap_data", i), cap_data, tbl[i].d);
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].b));
      check($sformatf("vec%0d.last_id", i), 32'(last_id), 32'(tbl[i].l));
    end

    // All four requests held: rotating grants, 6 cycles apart.
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step(1'b1, 1'b0, 4'b0000, 32'h0);
    cap_n = 0;
    prev_t = -1;
    for (int t = 0; t < 25; t++) begin
      step(1'b0, 1'b1, 4'b1111, 32'(t));
      if (capture) begin
        if (cap_n < 5) check("rr_all.grant", 32'(grant), 32'(exp_g[cap_n]));
        if (prev_t >= 0) check("rr_all.spacing", 32'(t - prev_t), 32'd6);
        prev_t = t;
        cap_n++;
      end
    end
    check("rr_all.count", 32'(cap_n), 32'd5);

    // Enable gating and withdrawal during HOLD.
    step(1'b1, 1'b0, 4'b0000, 32'h0);
    cap_n = 0;
    for (int t = 0; t < 10; t++) begin
      step(1'b0, 1'b0, 4'b1000, 32'h0);
      if (capture) cap_n++;
    end
    check("en_low.captures", 32'(cap_n), 32'd0);
    step(1'b0, 1'b1, 4'b1000, 32'hAA);
    check("en_rise.capture", 32'(capture), 32'd1);
    check("en_rise.grant", 32'(grant), 32'b1000);
    step(1'b0, 1'b1, 4'b0011, 32'h0);
    step(1'b0, 1'b1, 4'b0010, 32'h0);
    got = 0;
    for (int t = 0; t < 8 && got == 0; t++) begin
      step(1'b0, 1'b1, 4'b0010, 32'h0);
      if (capture) begin
        got = 1;
        check("withdraw.grant", 32'(grant), 32'b0010);
      end
    end
    if (got == 0) check("withdraw.timeout", 32'd0, 32'd1);

    // Zero gap: pulses every 2 cycles, alternating requesters 0 and 1.
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0; en0 = 1'b1; req0 = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("gap0.capture%0d", k), 32'(capture0), 32'((k % 2) == 0));
      check($sformatf("gap0.grant%0d", k), 32'(grant0),
            (k % 4 == 0) ? 32'b0001 : (k % 4 == 2) ? 32'b0010 : 32'b0000);
    end

    // Randomized traffic against the reference model.
    step(1'b1, 1'b0, 4'b0000, 32'h0);
    check_model("rand_reset");
    for (int t = 0; t < 1500; t++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
           4'($urandom), $urandom);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
